// File: rtl/cjb_pb_sw_conditioner_pkg.sv
// Shared constants and state encoding for the push-button / switch conditioner.
package cjb_pb_sw_conditioner_pkg;

  localparam int unsigned DB_CYCLES_DEFAULT = 16;
  localparam int unsigned CNT_W_DEFAULT     = 5;
  localparam int unsigned SW_W              = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StHeld = 1'b1
  } press_state_e;

endpackage

// File: rtl/cjb_debounce_v.sv
// Single-bit two-flop synchroniser followed by a saturating-compare debouncer.
module cjb_debounce_v
  import cjb_pb_sw_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_db
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  logic             w_db_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // The counter only runs while the synchronised level disagrees with the
  // debounced level; any agreeing sample restarts the stability window.
  always_comb begin
    w_db_nxt  = r_db;
    w_cnt_nxt = '0;
    if (r_sync2 != r_db) begin
      if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
        w_db_nxt = ~r_db;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_db    <= w_db_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/cjb_pb_sw_conditioner.sv
// Debounces PB1 and four switches, then captures the switch value on each press
// and tracks unread / overrun status for the processor input port.
module cjb_pb_sw_conditioner
  import cjb_pb_sw_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PB1_raw,
  input  logic [3:0] SW_raw,
  input  logic       rd_ack,
  output logic       PB1,
  output logic [3:0] SW,
  output logic       PB1_pulse,
  output logic [3:0] SW_cap,
  output logic       in_valid,
  output logic       overrun
);

  logic            w_pb1_db;
  logic [SW_W-1:0] w_sw_db;

  cjb_debounce_v #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_db_pb1 (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_raw   (PB1_raw),
    .o_db    (w_pb1_db)
  );

  for (genvar g = 0; g < SW_W; g++) begin : g_sw_db
    cjb_debounce_v #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_db_sw (
      .i_clk   (Clock),
      .i_rst_n (Reset),
      .i_raw   (SW_raw[g]),
      .o_db    (w_sw_db[g])
    );
  end

  press_state_e    r_state;
  press_state_e    w_state_nxt;
  logic            w_capture;

  logic            r_pulse;
  logic [SW_W-1:0] r_sw_cap;
  logic            r_in_valid;
  logic            r_overrun;

  logic [SW_W-1:0] w_sw_cap_nxt;
  logic            w_in_valid_nxt;
  logic            w_overrun_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_pb1_db) begin
          w_state_nxt = StHeld;
          w_capture   = 1'b1;
        end
      end
      StHeld: begin
        if (!w_pb1_db) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // A capture beats a coincident acknowledge: the new value is unread, and the
  // old one counts as consumed rather than overrun.
  always_comb begin
    w_sw_cap_nxt   = r_sw_cap;
    w_in_valid_nxt = r_in_valid;
    w_overrun_nxt  = r_overrun;
    if (w_capture) begin
      w_sw_cap_nxt   = w_sw_db;
      w_in_valid_nxt = 1'b1;
      w_overrun_nxt  = r_in_valid & ~rd_ack;
    end else if (rd_ack && r_in_valid) begin
      w_in_valid_nxt = 1'b0;
      w_overrun_nxt  = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state    <= StIdle;
      r_pulse    <= 1'b0;
      r_sw_cap   <= '0;
      r_in_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pulse    <= w_capture;
      r_sw_cap   <= w_sw_cap_nxt;
      r_in_valid <= w_in_valid_nxt;
      r_overrun  <= w_overrun_nxt;
    end
  end

  assign PB1       = w_pb1_db;
  assign SW        = w_sw_db;
  assign PB1_pulse = r_pulse;
  assign SW_cap    = r_sw_cap;
  assign in_valid  = r_in_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_cjb_pb_sw_conditioner.sv
// Directed bench for cjb_pb_sw_conditioner with DB_CYCLES = 4.
module tb_cjb_pb_sw_conditioner;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       PB1_raw = 1'b0;
  logic [3:0] SW_raw = 4'b0000;
  logic       rd_ack = 1'b0;
  logic       PB1;
  logic [3:0] SW;
  logic       PB1_pulse;
  logic [3:0] SW_cap;
  logic       in_valid;
  logic       overrun;

  int n_checks  = 0;
  int n_fail    = 0;
  int pulse_cnt = 0;

  always #5 Clock = ~Clock;

  cjb_pb_sw_conditioner #(
    .DB_CYCLES (4),
    .CNT_W     (3)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .PB1_raw   (PB1_raw),
    .SW_raw    (SW_raw),
    .rd_ack    (rd_ack),
    .PB1       (PB1),
    .SW        (SW),
    .PB1_pulse (PB1_pulse),
    .SW_cap    (SW_cap),
    .in_valid  (in_valid),
    .overrun   (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 time unit after each one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
      if (PB1_pulse) pulse_cnt++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".PB1"},       32'(PB1),       32'd0);
    check_eq({tag, ".SW"},        32'(SW),        32'd0);
    check_eq({tag, ".PB1_pulse"}, 32'(PB1_pulse), 32'd0);
    check_eq({tag, ".SW_cap"},    32'(SW_cap),    32'd0);
    check_eq({tag, ".in_valid"},  32'(in_valid),  32'd0);
    check_eq({tag, ".overrun"},   32'(overrun),   32'd0);
  endtask

  task automatic press(input logic [3:0] sw);
    SW_raw = sw;
    tick(8);
    PB1_raw = 1'b1;
    tick(10);
    PB1_raw = 1'b0;
    tick(10);
  endtask

  initial begin
    // Reset state
    tick(3);
    check_all_zero("reset");
    Reset = 1'b1;

    // Switch change lands exactly DB_CYCLES+2 = 6 edges later, no pulse
    pulse_cnt = 0;
    SW_raw = 4'b1010;
    tick(5);
    check_eq("sw_edge5", 32'(SW), 32'h0);
    tick(1);
    check_eq("sw_edge6", 32'(SW), 32'hA);
    tick(4);
    check_eq("sw_no_pulse", 32'(pulse_cnt), 32'd0);

    // Three 3-cycle glitches on PB1 are rejected
    for (int k = 0; k < 3; k++) begin
      PB1_raw = 1'b1;
      tick(3);
      PB1_raw = 1'b0;
      tick(3);
    end
    tick(6);
    check_eq("glitch_pb1",      32'(PB1),       32'd0);
    check_eq("glitch_pulse",    32'(pulse_cnt), 32'd0);
    check_eq("glitch_in_valid", 32'(in_valid),  32'd0);

    // Long hold gives one pulse and a capture
    SW_raw = 4'b0110;
    tick(8);
    PB1_raw = 1'b1;
    tick(50);
    check_eq("hold_pulse_cnt", 32'(pulse_cnt), 32'd1);
    check_eq("hold_sw_cap",    32'(SW_cap),    32'h6);
    check_eq("hold_in_valid",  32'(in_valid),  32'd1);
    check_eq("hold_pb1",       32'(PB1),       32'd1);
    PB1_raw = 1'b0;
    tick(10);
    check_eq("release_pb1",      32'(PB1),       32'd0);
    check_eq("release_in_valid", 32'(in_valid),  32'd1);
    check_eq("release_pulse",    32'(pulse_cnt), 32'd1);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    check_eq("ack_in_valid", 32'(in_valid), 32'd0);
    check_eq("ack_overrun",  32'(overrun),  32'd0);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    check_eq("idle_ack_in_valid", 32'(in_valid), 32'd0);
    check_eq("idle_ack_sw_cap",   32'(SW_cap),   32'h6);

    // Two unread presses give overrun
    pulse_cnt = 0;
    press(4'b0001);
    check_eq("p1_sw_cap",  32'(SW_cap),  32'h1);
    check_eq("p1_overrun", 32'(overrun), 32'd0);
    press(4'b0011);
    check_eq("p2_sw_cap",   32'(SW_cap),    32'h3);
    check_eq("p2_overrun",  32'(overrun),   32'd1);
    check_eq("p2_in_valid", 32'(in_valid),  32'd1);
    check_eq("p2_pulses",   32'(pulse_cnt), 32'd2);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    check_eq("p2_ack_in_valid", 32'(in_valid), 32'd0);
    check_eq("p2_ack_overrun",  32'(overrun),  32'd0);

    // rd_ack coincident with the capture edge (edge 7 after press)
    press(4'b0101);
    SW_raw = 4'b1100;
    tick(8);
    pulse_cnt = 0;
    PB1_raw = 1'b1;
    tick(6);
    check_eq("coin_pre_pulse",   32'(pulse_cnt), 32'd0);
    check_eq("coin_pre_sw_cap",  32'(SW_cap),    32'h5);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    check_eq("coin_pulse",    32'(PB1_pulse), 32'd1);
    check_eq("coin_in_valid", 32'(in_valid),  32'd1);
    check_eq("coin_overrun",  32'(overrun),   32'd0);
    check_eq("coin_sw_cap",   32'(SW_cap),    32'hC);
    PB1_raw = 1'b0;
    tick(10);

    // Reset while HELD, then button still down after release
    PB1_raw = 1'b1;
    tick(10);
    check_eq("held_in_valid", 32'(in_valid), 32'd1);
    Reset = 1'b0;
    tick(1);
    Reset = 1'b1;
    check_all_zero("mid_reset");
    pulse_cnt = 0;
    tick(6);
    check_eq("rr_pre_pulse", 32'(pulse_cnt), 32'd0);
    tick(1);
    check_eq("rr_pulse_edge7", 32'(PB1_pulse), 32'd1);
    tick(20);
    check_eq("rr_pulse_cnt", 32'(pulse_cnt), 32'd1);
    check_eq("rr_sw_cap",    32'(SW_cap),    32'hC);
    check_eq("rr_in_valid",  32'(in_valid),  32'd1);
    check_eq("rr_overrun",   32'(overrun),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cjb_pb_sw_conditioner.md
CJB_PB_SW_CONDITIONER -- requirements
Module: cjb_pb_sw_conditioner

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 16, the number of consecutive stable synchronised samples required before a debounced output changes (minimum 2).
REQ-002 The block SHALL have parameter CNT_W, default 5, the debounce counter width, which SHALL satisfy 2**CNT_W > DB_CYCLES.
REQ-003 Clock  input  1  the single system clock; all state SHALL update on its rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 PB1_raw  input  1  asynchronous push-button level from the board (1 = pressed).
REQ-006 SW_raw  input  4  asynchronous slide-switch levels from the board.
REQ-007 rd_ack  input  1  one-cycle strobe from the processor input port indicating that SW_cap has been loaded into IPDR.
REQ-008 PB1  output  1  debounced push-button level, fed to the processor datapath.
REQ-009 SW  output  4  debounced switch levels.
REQ-010 PB1_pulse  output  1  one-cycle strobe on each debounced press.
REQ-011 SW_cap  output  4  SW value captured at the most recent debounced press.
REQ-012 in_valid  output  1  sticky flag: a press has been captured and not yet acknowledged.
REQ-013 overrun  output  1  sticky flag: a press occurred while in_valid was already 1.

Function
REQ-014 Each raw bit SHALL pass through a two-flop synchroniser before it is used.
REQ-015 Per-bit debounce SHALL work as follows: if the synchronised value equals the debounced value, the counter SHALL clear; otherwise the counter SHALL increment.
REQ-016 When the counter reaches DB_CYCLES-1 and the synchronised value still differs, the debounced value SHALL toggle and the counter SHALL clear on that edge.
REQ-017 A clean raw level change SHALL reach PB1/SW exactly DB_CYCLES+2 rising edges after the first edge that samples the new level.
REQ-018 Any glitch shorter than DB_CYCLES synchronised samples SHALL produce no change on PB1 or SW.
REQ-019 The press FSM SHALL have two states, IDLE and HELD.
REQ-020 In IDLE, when debounced PB1 is 1, the FSM SHALL go to HELD, assert PB1_pulse for exactly the next cycle, load SW_cap from debounced SW, and set in_valid.
REQ-021 In HELD, the FSM SHALL stay until debounced PB1 is 0, then return to IDLE without asserting any strobe.
REQ-022 The block SHALL assert PB1_pulse at most once per press, regardless of hold duration.
REQ-023 rd_ack SHALL clear in_valid and overrun on the next edge.
REQ-024 rd_ack while in_valid is 0 SHALL have no effect.
REQ-025 If rd_ack coincides with a new press capture, the set SHALL win: in_valid = 1, SW_cap takes the new value, and overrun = 0.
REQ-026 A press while in_valid = 1 and without rd_ack SHALL overwrite SW_cap and set overrun.
REQ-027 The block SHALL keep SW_cap stable at all times other than a capture edge.

Reset
REQ-028 While Reset = 0 at a rising edge, the block SHALL set: synchroniser flops = 0, counters = 0, PB1 = 0, SW = 0000, PB1_pulse = 0, SW_cap = 0000, in_valid = 0, overrun = 0, FSM = IDLE.
REQ-029 Reset asserted mid-debounce or in HELD SHALL abandon the operation with no pulse.
REQ-030 After reset release with PB1_raw held at 1, the block SHALL treat this as a new press: exactly one PB1_pulse, DB_CYCLES+3 edges after release.

Structure
REQ-031 The FSM state encodings (IDLE = 0, HELD = 1) and the default DB_CYCLES SHALL live in a shared project include file of constants.
REQ-032 Per-bit synchronise-and-debounce SHALL be a sub-module, cjb_debounce_v, instantiated five times (PB1 plus 4 SW bits).
REQ-033 The FSM and the capture/flag logic SHALL reside in cjb_pb_sw_conditioner.

Verification
REQ-034 DB_CYCLES = 4: SW_raw 0000 -> 1010 held -> SW = 1010 exactly 6 edges later; PB1_pulse stays 0.
REQ-035 DB_CYCLES = 4: PB1_raw pulses high for 3 cycles, 3 times -> PB1 stays 0, no pulse, in_valid = 0.
REQ-036 SW_raw = 0110 stable, then PB1_raw held 50 cycles -> one PB1_pulse, SW_cap = 0110, in_valid = 1; release, then rd_ack -> in_valid = 0.
REQ-037 Two presses with no rd_ack (SW 0001, then 0011) -> SW_cap = 0011, overrun = 1; rd_ack -> both flags 0.
REQ-038 rd_ack coincident with a capture edge -> in_valid = 1, overrun = 0, SW_cap = new value.
REQ-039 Reset = 0 for 1 cycle while in HELD with in_valid = 1 -> all outputs 0 next edge; PB1_raw still 1 -> one pulse 7 edges after release.
